// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 raster timing constants and coordinate type
package vga_pkg;
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic SYNC_ACT = 1'b0;
endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing outputs toward the display/video consumer
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   pix_tick;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_tick;
    coord_t px;
    coord_t py;

    modport master (output pix_tick, hsync, vsync, video_on, frame_tick, px, py);
    modport slave  (input  pix_tick, hsync, vsync, video_on, frame_tick, px, py);
endinterface

// File: rtl/vga_axis_ctr.sv
// rtl/vga_axis_ctr.sv - wrapping raster axis counter with enable and carry-out
module vga_axis_ctr
    import vga_pkg::*;
#(
    parameter coord_t LAST = coord_t'(H_TOT - 1)
) (
    input  logic   clk,
    input  logic   clr_n,
    input  logic   en,
    output coord_t count,
    output coord_t count_nxt,
    output logic   carry
);
    always_comb begin
        carry     = en && (count == LAST);
        count_nxt = count;
        if (en) begin
            count_nxt = (count == LAST) ? '0 : count + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - dclk edge strobe, raster counters, registered sync/video decode
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS    = vga_pkg::H_VIS,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_VIS    = vga_pkg::V_VIS,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_ACT = vga_pkg::SYNC_ACT
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              dclk,
    vga_timing_gen_if.master  vga
);
    localparam int     H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int     V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS_C = coord_t'(H_VIS);
    localparam coord_t V_VIS_C = coord_t'(V_VIS);
    localparam coord_t HS0     = coord_t'(H_VIS + H_FP);
    localparam coord_t HS1     = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS0     = coord_t'(V_VIS + V_FP);
    localparam coord_t VS1     = coord_t'(V_VIS + V_FP + V_SYNC);

    logic   dclk_d, pix_tick;
    logic   hsync, vsync, video_on, frame_tick;
    coord_t h_cnt, h_nxt, v_cnt, v_nxt;
    logic   h_carry, v_carry_unused;

    vga_axis_ctr #(.LAST(H_LAST)) u_hctr (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (pix_tick),
        .count     (h_cnt),
        .count_nxt (h_nxt),
        .carry     (h_carry)
    );

    vga_axis_ctr #(.LAST(V_LAST)) u_vctr (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (h_carry),
        .count     (v_cnt),
        .count_nxt (v_nxt),
        .carry     (v_carry_unused)
    );

    // Decode from the next counter values so sync/video stay aligned with px/py.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            dclk_d     <= 1'b0;
            pix_tick   <= 1'b0;
            hsync      <= ~SYNC_ACT;
            vsync      <= ~SYNC_ACT;
            video_on   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            dclk_d     <= dclk;
            pix_tick   <= dclk & ~dclk_d;
            frame_tick <= h_carry && (v_nxt == V_VIS_C);
            if (pix_tick) begin
                hsync    <= ((h_nxt >= HS0) && (h_nxt < HS1)) ? SYNC_ACT : ~SYNC_ACT;
                vsync    <= ((v_nxt >= VS0) && (v_nxt < VS1)) ? SYNC_ACT : ~SYNC_ACT;
                video_on <= (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
            end
        end
    end

    assign vga.pix_tick   = pix_tick;
    assign vga.hsync      = hsync;
    assign vga.vsync      = vsync;
    assign vga.video_on   = video_on;
    assign vga.frame_tick = frame_tick;
    assign vga.px         = h_cnt;
    assign vga.py         = v_cnt;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - full-size and shrunken raster instances checked against a position model
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic clr_n;
    logic dclk;

    always #5 clk = ~clk;

    vga_timing_gen_if v0 ();
    vga_timing_gen_if v1 ();

    vga_timing_gen u0 (.clk(clk), .clr_n(clr_n), .dclk(dclk), .vga(v0));

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u1 (.clk(clk), .clr_n(clr_n), .dclk(dclk), .vga(v1));

    int htot [2] = '{800, 16};
    int vtot [2] = '{525, 11};
    int hvis [2] = '{640, 8};
    int vvis [2] = '{480, 6};
    int hs0  [2] = '{656, 10};
    int hs1  [2] = '{752, 13};
    int vs0  [2] = '{490, 7};
    int vs1  [2] = '{492, 9};

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string nm;
        int    act;
        int    exp;
    } lit_t;
    lit_t lq[$];

    bit freeze   = 1'b1;
    bit model_on = 1'b0;
    int dcnt     = 0;

    // Model: raster position as a linear pixel index within the frame.
    bit m_prev [2];
    bit m_tick [2];
    int m_pos  [2];
    bit m_start[2];
    bit m_frame[2];

    function automatic int cur_px(input int k);
        return (k == 0) ? int'(v0.px) : int'(v1.px);
    endfunction
    function automatic int cur_py(input int k);
        return (k == 0) ? int'(v0.py) : int'(v1.py);
    endfunction
    function automatic int cur_tick(input int k);
        return (k == 0) ? int'(v0.pix_tick) : int'(v1.pix_tick);
    endfunction

    task automatic lit(input string nm, input int act, input int exp);
        lq.push_back('{nm, act, exp});
    endtask

    task automatic cmp(input string nm, input int k, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!freeze) begin
                dcnt++;
                dclk = dcnt[1];
            end
        end
    end

    always @(posedge clk) begin
        int np;
        for (int k = 0; k < 2; k++) begin
            if (!clr_n) begin
                m_prev[k]  <= 1'b0;
                m_tick[k]  <= 1'b0;
                m_pos[k]   <= 0;
                m_start[k] <= 1'b0;
                m_frame[k] <= 1'b0;
            end else begin
                m_prev[k] <= dclk;
                m_tick[k] <= dclk & ~m_prev[k];
                if (m_tick[k]) begin
                    np = (m_pos[k] + 1) % (htot[k] * vtot[k]);
                    m_pos[k]   <= np;
                    m_start[k] <= 1'b1;
                    m_frame[k] <= (np == vvis[k] * htot[k]);
                end else begin
                    m_frame[k] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        int ex_px, ex_py, ex_tk, ex_hs, ex_vs, ex_vo, ex_ft;
        lit_t e;
        while (lq.size() > 0) begin
            e = lq.pop_front();
            cmp(e.nm, 0, e.act, e.exp);
        end
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                if (!clr_n) begin
                    ex_px = 0; ex_py = 0; ex_tk = 0; ex_hs = 1; ex_vs = 1; ex_vo = 0; ex_ft = 0;
                end else begin
                    ex_px = m_pos[k] % htot[k];
                    ex_py = m_pos[k] / htot[k];
                    ex_tk = int'(m_tick[k]);
                    ex_hs = (ex_px >= hs0[k] && ex_px < hs1[k]) ? 0 : 1;
                    ex_vs = (ex_py >= vs0[k] && ex_py < vs1[k]) ? 0 : 1;
                    ex_vo = (m_start[k] && ex_px < hvis[k] && ex_py < vvis[k]) ? 1 : 0;
                    ex_ft = int'(m_frame[k]);
                end
                cmp("px", k, cur_px(k), ex_px);
                cmp("py", k, cur_py(k), ex_py);
                cmp("pix_tick", k, cur_tick(k), ex_tk);
                cmp("hsync", k, (k == 0) ? int'(v0.hsync) : int'(v1.hsync), ex_hs);
                cmp("vsync", k, (k == 0) ? int'(v0.vsync) : int'(v1.vsync), ex_vs);
                cmp("video_on", k, (k == 0) ? int'(v0.video_on) : int'(v1.video_on), ex_vo);
                cmp("frame_tick", k, (k == 0) ? int'(v0.frame_tick) : int'(v1.frame_tick), ex_ft);
            end
        end
    end

    task automatic wait_at(input int k, input int tpx, input int tpy, input int budget,
                           output int ticks);
        bit hit;
        hit   = 1'b0;
        ticks = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (cur_px(k) == tpx && (tpy < 0 || cur_py(k) == tpy)) begin
                hit = 1'b1;
                break;
            end
            ticks += cur_tick(k);
        end
        if (!hit) lit($sformatf("timeout_reach_%0d_%0d", tpx, tpy), 0, 1);
    endtask

    task automatic wait_tick(input int k, input string nm);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (cur_tick(k) == 1) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) lit(nm, 0, 1);
    endtask

    initial begin
        int t;
        int op;
        clr_n = 1'b1;
        dclk  = 1'b0;
        #1 clr_n = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
        model_on = 1'b1;
        repeat (20) @(posedge clk);
        #1 clr_n = 1'b1;

        wait_at(0, 656, 0, 4000, t);
        lit("hsync_fall_656", int'(v0.hsync), 0);
        lit("model_px_656", m_pos[0] % 800, 656);
        wait_at(0, 752, 0, 1000, t);
        lit("hsync_low_ticks", t, 96);
        lit("hsync_rise_752", int'(v0.hsync), 1);
        wait_at(0, 799, 0, 1000, t);
        wait_at(0, 0, 1, 20, t);
        lit("line_wrap_ticks", t, 1);
        lit("video_on_0_1", int'(v0.video_on), 1);
        lit("model_pos_0_1", m_pos[0], 800);

        wait_at(0, 299, 1, 2000, t);
        wait_tick(0, "timeout_tick_299");
        lit("dclk_high_at_freeze", int'(dclk), 1);
        freeze = 1'b1;
        t = 0;
        repeat (100) begin
            @(negedge clk);
            t += cur_tick(0);
        end
        lit("stall_ticks", t, 0);
        lit("stall_px_300", cur_px(0), 300);
        freeze = 1'b0;
        wait_tick(0, "timeout_tick_resume");
        @(negedge clk);
        lit("resume_px_301", cur_px(0), 301);

        wait_at(0, 400, -1, 1000, t);
        @(posedge clk);
        #1 clr_n = 1'b0;
        @(negedge clk);
        lit("rst_px", cur_px(0), 0);
        lit("rst_py", cur_py(0), 0);
        lit("rst_hsync", int'(v0.hsync), 1);
        lit("rst_vsync", int'(v0.vsync), 1);
        lit("rst_video_on", int'(v0.video_on), 0);
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;
        wait_tick(0, "timeout_tick_after_rst");
        @(negedge clk);
        lit("post_rst_px_1", cur_px(0), 1);
        lit("post_rst_py_0", cur_py(0), 0);

        wait_at(1, 0, 6, 2000, t);
        lit("small_frame_tick", int'(v1.frame_tick), 1);
        lit("model_frame_tick", int'(m_frame[1]), 1);
        @(negedge clk);
        lit("small_frame_tick_off", int'(v1.frame_tick), 0);
        wait_at(1, 0, 7, 200, t);
        lit("small_vsync_on", int'(v1.vsync), 0);
        wait_at(1, 0, 9, 300, t);
        lit("small_vsync_ticks", t, 32);
        lit("small_vsync_off", int'(v1.vsync), 1);
        wait_at(1, 15, 10, 400, t);
        wait_at(1, 0, 0, 20, t);
        lit("small_wrap_ticks", t, 1);
        lit("small_wrap_py", cur_py(1), 0);

        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            @(posedge clk);
            #1;
            if (op == 0) begin
                clr_n = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1 clr_n = 1'b1;
            end else if (op <= 3) begin
                freeze = 1'b1;
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1 freeze = 1'b0;
            end else begin
                repeat ($urandom_range(10, 200)) @(posedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
